// File: rtl/sram_test_defs.sv
// Shared definitions for the SRAM test sequencer: FSM encodings and the
// standard data patterns used by pattern sources.
package sram_test_defs;

    localparam int STATE_BITS = 3;

    localparam logic [STATE_BITS-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_BITS-1:0] ST_WRITE     = 3'd1;
    localparam logic [STATE_BITS-1:0] ST_READ      = 3'd2;
    localparam logic [STATE_BITS-1:0] ST_READ_WAIT = 3'd3;
    localparam logic [STATE_BITS-1:0] ST_NEXT_PAT  = 3'd4;
    localparam logic [STATE_BITS-1:0] ST_DONE      = 3'd5;

    localparam logic [15:0] PAT_ZEROS       = 16'h0000;
    localparam logic [15:0] PAT_ONES        = 16'hFFFF;
    localparam logic [15:0] PAT_CHECKER     = 16'h5555;
    localparam logic [15:0] PAT_INV_CHECKER = 16'hAAAA;

    function automatic logic state_is_busy(input logic [STATE_BITS-1:0] st);
        return (st != ST_IDLE) && (st != ST_DONE);
    endfunction

endpackage

// File: rtl/addr_counter.sv
// Memory address counter; wraps by natural overflow, last flags the top address.
module addr_counter #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] addr,
    output logic             last
);

    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] addr_d;

    // NOTE: defaulting every combinational output first is what keeps a latch from being inferred.
    always_comb begin
        addr_d = addr_q;
        if (clear) begin
            addr_d = '0;
        end else if (inc) begin
            addr_d = addr_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;
    assign last = &addr_q;

endmodule

// File: rtl/sram_test_sequencer.sv
// Write/read-back SRAM tester: fills memory with each pattern, verifies it,
// stops at the first miscompare and reports pass once the pattern source is exhausted.
module sram_test_sequencer
    import sram_test_defs::*;
#(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] pattern,
    input  logic                 pattern_done,
    output logic                 pattern_next,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 pass,
    output logic                 fail,
    output logic [ADDR_BITS-1:0] fail_addr,
    output logic [DATA_BITS-1:0] fail_expected,
    output logic [DATA_BITS-1:0] fail_actual
);

    logic [STATE_BITS-1:0] state_q, state_d;
    logic                  np_wait_q, np_wait_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic [ADDR_BITS-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_BITS-1:0]  fail_exp_q, fail_exp_d;
    logic [DATA_BITS-1:0]  fail_act_q, fail_act_d;

    logic                  addr_inc;
    logic                  addr_clear;
    logic [ADDR_BITS-1:0]  addr;
    logic                  addr_last;

    addr_counter #(.WIDTH(ADDR_BITS)) u_addr_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (addr_inc),
        .clear   (addr_clear),
        .addr    (addr),
        .last    (addr_last)
    );

    always_comb begin
        state_d     = state_q;
        np_wait_d   = np_wait_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_exp_d  = fail_exp_q;
        fail_act_d  = fail_act_q;
        addr_inc    = 1'b0;
        addr_clear  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    addr_clear = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ready) begin
                    addr_inc = 1'b1;
                    if (addr_last) state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (mem_ready) state_d = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (mem_rvalid) begin
                    if (mem_rdata != pattern) begin
                        fail_d      = 1'b1;
                        fail_addr_d = addr;
                        fail_exp_d  = pattern;
                        fail_act_d  = mem_rdata;
                        state_d     = ST_DONE;
                    end else begin
                        addr_inc = 1'b1;
                        state_d  = addr_last ? ST_NEXT_PAT : ST_READ;
                    end
                end
            end
            ST_NEXT_PAT: begin
                // First cycle advances the source, second sees the settled pattern_done.
                if (!np_wait_q) begin
                    np_wait_d = 1'b1;
                end else begin
                    np_wait_d = 1'b0;
                    if (pattern_done) begin
                        pass_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        addr_clear = 1'b1;
                        state_d    = ST_WRITE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            np_wait_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            state_q     <= state_d;
            np_wait_q   <= np_wait_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_exp_q  <= fail_exp_d;
            fail_act_q  <= fail_act_d;
        end
    end

    assign mem_req       = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign mem_we        = (state_q == ST_WRITE);
    assign mem_addr      = addr;
    assign mem_wdata     = (state_q == ST_WRITE) ? pattern : '0;
    assign pattern_next  = (state_q == ST_NEXT_PAT) && !np_wait_q;
    assign busy          = state_is_busy(state_q);
    assign pass          = pass_q;
    assign fail          = fail_q;
    assign fail_addr     = fail_addr_q;
    assign fail_expected = fail_exp_q;
    assign fail_actual   = fail_act_q;

endmodule

// File: doc/sram_test_sequencer.md
SRAM_TEST_SEQUENCER -- requirements
Module: sram_test_sequencer

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 20: memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16: memory and pattern data width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle pulse to begin a test run.
REQ-006 SHALL have port pattern, input, DATA_BITS: current test pattern from the pattern source.
REQ-007 SHALL have port pattern_done, input, 1: high once the pattern source has passed its final pattern.
REQ-008 SHALL have port pattern_next, output, 1: one-cycle pulse that advances the pattern source.
REQ-009 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_BITS), mem_wdata (out, DATA_BITS), mem_ready (in, 1): memory request handshake.
REQ-010 SHALL have ports mem_rvalid (in, 1) and mem_rdata (in, DATA_BITS): read return.
REQ-011 SHALL have outputs busy (1), pass (1), fail (1), fail_addr (ADDR_BITS), fail_expected (DATA_BITS), fail_actual (DATA_BITS).

Function
REQ-012 SHALL implement states IDLE, WRITE, READ, READ_WAIT, NEXT_PAT, DONE.
REQ-013 IDLE: on start, SHALL clear pass/fail, set address 0, and enter WRITE next cycle; busy SHALL be high in every state except IDLE and DONE.
REQ-014 WRITE: SHALL hold mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=pattern until the cycle with mem_req&&mem_ready; that cycle completes the write.
REQ-015 After a write to addr 2^ADDR_BITS-1, the address SHALL wrap to 0 and the state SHALL go to READ; otherwise the address SHALL increment and WRITE SHALL continue.
REQ-016 READ: SHALL hold mem_req=1, mem_we=0, mem_addr=addr until mem_ready, then go to READ_WAIT; there SHALL be at most one outstanding read.
REQ-017 READ_WAIT: mem_req SHALL be 0; on mem_rvalid, mem_rdata SHALL be compared with pattern in the same cycle.
REQ-018 On a mismatch, the block SHALL capture fail_addr=addr, fail_expected=pattern and fail_actual=mem_rdata, set fail=1, and go to DONE (stop on first failure).
REQ-019 On a match at the last address, the state SHALL go to NEXT_PAT; otherwise the address SHALL increment and READ SHALL follow.
REQ-020 NEXT_PAT: SHALL pulse pattern_next for exactly one cycle, wait one further cycle for the pattern to settle, then go to DONE with pass=1 if pattern_done=1, else to WRITE at address 0.
REQ-021 DONE: SHALL hold pass/fail and fail_* stable; start SHALL begin a new run as from IDLE.
REQ-022 start while busy SHALL be ignored.
REQ-023 mem_rvalid outside READ_WAIT SHALL be ignored.
REQ-024 pass and fail SHALL never be high together.
REQ-025 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-026 The address counter SHALL be exactly ADDR_BITS wide; wrap SHALL use natural overflow.

Reset
REQ-027 When reset_n=0 at a clock edge, the block SHALL enter IDLE and drive to 0: mem_req, mem_we, mem_addr, mem_wdata, pattern_next, busy, pass, fail, fail_addr, fail_expected, fail_actual.
REQ-028 Reset mid-run SHALL abandon any outstanding read; a later mem_rvalid SHALL be ignored.
REQ-029 Resetting the pattern source SHALL be the integrator's responsibility, using the same reset.

Structure
REQ-030 State encodings SHALL live in a shared package/include (sram_test_defs), together with the shared pattern localparams.
REQ-031 The address counter with wrap flag SHALL be a sub-module, addr_counter (inc, clear, addr, last).
REQ-032 The comparator and capture registers SHALL remain inline.

Verification (ADDR_BITS=2, DATA_BITS=16, behavioural SRAM model)
REQ-033 Zero-wait memory, 7-pattern source -> 7×(4 writes + 4 reads), 7 pattern_next pulses, pass=1, busy=0.
REQ-034 Model forces addr 2 bit0 stuck-0, first pattern 0xFFFF -> fail=1, fail_addr=2, fail_expected=0xFFFF, fail_actual=0xFFFE, no further mem_req.
REQ-035 Random mem_ready stalls and 0–5 cycle rvalid latency -> pass=1, and mem_addr/mem_wdata stable during every stall.
REQ-036 start pulsed mid-run -> no restart, address sequence unchanged, and a final pass.
REQ-037 reset_n low during READ_WAIT, stale mem_rvalid 2 cycles after reset -> IDLE, all outputs 0, no fail.
REQ-038 Second start from DONE after a failure -> fail cleared, address restarts at 0.
